// File: rtl/nn_inference_ctrl_if.sv
// ---------------------------------------------------------------------------
// nn_inference_ctrl_if
// Purpose : groups the frame-in handshake, the pipeline-facing data and the
//           result handshake of nn_inference_ctrl into one bundle.
// Signals :
//   in_valid / in_ready      feature frame handshake (producer -> controller)
//   in_vector                IN_SIZE x IN_W feature frame from producer
//   nn_input_vector          registered frame driven into the dense pipeline
//   nn_output_value          class index coming back from final_layer
//   res_valid / res_ready    result handshake (controller -> consumer)
//   res_class                captured class index
//   busy                     controller is not idle
//   infer_count              completed-inference counter (NN_CTRL_PERF_EN only)
// Modports:
//   master : the controller side (drives in_ready, nn_input_vector, res_*)
//   slave  : the surrounding system (producer, pipeline, consumer)
// ---------------------------------------------------------------------------
interface nn_inference_ctrl_if #(
    parameter int IN_SIZE = 13,
    parameter int IN_W    = 16,
    parameter int CLASS_W = 2
);
    logic                              in_valid;
    logic                              in_ready;
    logic [IN_SIZE-1:0][IN_W-1:0]      in_vector;
    logic [IN_SIZE-1:0][IN_W-1:0]      nn_input_vector;
    logic [CLASS_W-1:0]                nn_output_value;
    logic                              res_valid;
    logic                              res_ready;
    logic [CLASS_W-1:0]                res_class;
    logic                              busy;
`ifdef NN_CTRL_PERF_EN
    logic [15:0]                       infer_count;
`endif

    modport master (
`ifdef NN_CTRL_PERF_EN
        output infer_count,
`endif
        input  in_valid,
        output in_ready,
        input  in_vector,
        output nn_input_vector,
        input  nn_output_value,
        output res_valid,
        input  res_ready,
        output res_class,
        output busy
    );

    modport slave (
`ifdef NN_CTRL_PERF_EN
        input  infer_count,
`endif
        output in_valid,
        input  in_ready,
        output in_vector,
        input  nn_input_vector,
        output nn_output_value,
        input  res_valid,
        output res_ready,
        input  res_class,
        input  busy
    );
endinterface

// File: rtl/nn_inference_ctrl.sv
// ---------------------------------------------------------------------------
// nn_inference_ctrl
// Purpose : sequencer in front of the dense-layer inference pipeline
//           (dense_layer_1..4 + final_layer). Accepts one feature frame,
//           holds it stable on the pipeline input for the fixed pipeline
//           latency, captures the resulting class and offers it on a
//           valid/ready result port. Exactly one frame is in flight.
// Ports   :
//   clk   in   system clock, rising edge
//   rst   in   synchronous reset, active-high
//   bus   nn_inference_ctrl_if.master
//         in_valid/in_ready/in_vector, nn_input_vector, nn_output_value,
//         res_valid/res_ready/res_class, busy, infer_count (optional)
// Parameters:
//   IN_SIZE     feature elements per frame
//   IN_W        width of one feature element
//   NN_LATENCY  clocks from input change to valid nn_output_value (>= 1)
//   CLASS_W     width of the class index
// Build option:
//   NN_CTRL_PERF_EN  when defined, adds a saturating 16-bit count of
//                    completed inferences on bus.infer_count.
// ---------------------------------------------------------------------------
module nn_inference_ctrl #(
    parameter int IN_SIZE    = 13,
    parameter int IN_W       = 16,
    parameter int NN_LATENCY = 5,
    parameter int CLASS_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    nn_inference_ctrl_if.master  bus
);

    localparam int CNT_W = $clog2(NN_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t                        state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [IN_SIZE-1:0][IN_W-1:0]  vec_q, vec_d;
    logic [CLASS_W-1:0]            class_q, class_d;
    logic                          res_valid_q, res_valid_d;

    logic                          in_ready;
    logic                          in_hs;
    logic                          res_hs;

    // in_ready is masked by rst so a frame offered during reset is never
    // reported as accepted; the first acceptance is the edge after release.
    assign in_ready = (state_q == ST_IDLE) && !rst;
    assign in_hs    = bus.in_valid && in_ready;
    assign res_hs   = (state_q == ST_RESULT) && res_valid_q && bus.res_ready;

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            vec_q       <= '0;
            class_q     <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vec_q       <= vec_d;
            class_q     <= class_d;
            res_valid_q <= res_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vec_d       = vec_q;
        class_d     = class_q;
        res_valid_d = res_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (in_hs) begin
                    vec_d   = bus.in_vector;
                    // Loaded with LATENCY-1 so that the capture falls on the
                    // edge exactly NN_LATENCY clocks after the handshake.
                    cnt_d   = CNT_W'(NN_LATENCY - 1);
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (cnt_q == '0) begin
                    class_d     = bus.nn_output_value;
                    res_valid_d = 1'b1;
                    state_d     = ST_RESULT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_RESULT: begin
                // Return to IDLE only; a new frame cannot be taken on the
                // same edge as the result handshake.
                if (res_hs) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                res_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.in_ready        = in_ready;
    assign bus.nn_input_vector = vec_q;
    assign bus.res_valid       = res_valid_q;
    assign bus.res_class       = class_q;
    assign bus.busy            = (state_q != ST_IDLE);

`ifdef NN_CTRL_PERF_EN
    logic [15:0] infer_count_q, infer_count_d;

    // Saturating count of completed result handshakes.
    always_comb begin
        infer_count_d = infer_count_q;
        if (res_hs && (infer_count_q != 16'hFFFF)) begin
            infer_count_d = infer_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            infer_count_q <= 16'd0;
        end else begin
            infer_count_q <= infer_count_d;
        end
    end

    assign bus.infer_count = infer_count_q;
`endif

endmodule

// File: tb/tb_nn_inference_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nn_inference_ctrl
// Directed bench for nn_inference_ctrl with NN_LATENCY = 5. Inputs are
// driven and outputs sampled 1 time unit after each rising clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_nn_inference_ctrl;

    localparam int IN_SIZE    = 13;
    localparam int IN_W       = 16;
    localparam int NN_LATENCY = 5;
    localparam int CLASS_W    = 2;

    logic clk;
    logic rst;

    int checks;
    int errors;

    logic [IN_SIZE-1:0][IN_W-1:0] frame_a;
    logic [IN_SIZE-1:0][IN_W-1:0] frame_b;
    logic [IN_SIZE-1:0][IN_W-1:0] frame_c;
    logic [IN_SIZE-1:0][IN_W-1:0] zero_frame;

    nn_inference_ctrl_if #(
        .IN_SIZE (IN_SIZE),
        .IN_W    (IN_W),
        .CLASS_W (CLASS_W)
    ) bus ();

    nn_inference_ctrl #(
        .IN_SIZE    (IN_SIZE),
        .IN_W       (IN_W),
        .NN_LATENCY (NN_LATENCY),
        .CLASS_W    (CLASS_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_vec(input string tag, input logic [IN_SIZE-1:0][IN_W-1:0] exp);
        for (int i = 0; i < IN_SIZE; i++) begin
            chk($sformatf("%s[%0d]", tag, i), 64'(bus.nn_input_vector[i]), 64'(exp[i]));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;

        for (int i = 0; i < IN_SIZE; i++) begin
            frame_a[i]    = 16'h1000 + 16'(i);
            frame_b[i]    = 16'hA500 + 16'(i * 3);
            frame_c[i]    = 16'h0F00 + 16'(i * 7);
            zero_frame[i] = 16'h0000;
        end
        frame_a[0] = 16'h1234;
        frame_b[0] = 16'hBEEF;
        frame_c[0] = 16'h5A5A;

        // Reset with a frame already offered.
        rst                 = 1'b1;
        bus.in_valid        = 1'b1;
        bus.in_vector       = frame_a;
        bus.res_ready       = 1'b0;
        bus.nn_output_value = 2'd3;

        tick();
        chk("rst_in_ready_c1", 64'(bus.in_ready), 64'd0);
        tick();
        chk("rst_in_ready_c2", 64'(bus.in_ready), 64'd0);
        chk("rst_res_valid", 64'(bus.res_valid), 64'd0);

        // Release reset; in_valid still high, so E0 is the next edge.
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
        chk("idle_busy", 64'(bus.busy), 64'd0);
        chk("idle_res_valid", 64'(bus.res_valid), 64'd0);
        chk("idle_res_class", 64'(bus.res_class), 64'd0);
        chk_vec("idle_vec", zero_frame);

        // E0: frame A accepted.
        tick();
        chk_vec("e0_vec", frame_a);
        chk("e0_in_ready", 64'(bus.in_ready), 64'd0);
        chk("e0_busy", 64'(bus.busy), 64'd1);
        chk("e0_res_valid", 64'(bus.res_valid), 64'd0);

        // Offer a different frame during WAIT; it must be ignored.
        bus.in_vector = frame_b;
        for (int k = 1; k < NN_LATENCY; k++) begin
            tick();
            chk($sformatf("wait%0d_res_valid", k), 64'(bus.res_valid), 64'd0);
            chk($sformatf("wait%0d_vec0", k), 64'(bus.nn_input_vector[0]), 64'h1234);
            chk($sformatf("wait%0d_in_ready", k), 64'(bus.in_ready), 64'd0);
        end

        // E0+5: class captured.
        tick();
        chk("cap_res_valid", 64'(bus.res_valid), 64'd1);
        chk("cap_res_class", 64'(bus.res_class), 64'd3);
        chk_vec("cap_vec", frame_a);

        // Back-pressure: pipeline output moves, result must not.
        bus.nn_output_value = 2'd1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("bp%0d_res_valid", k), 64'(bus.res_valid), 64'd1);
            chk($sformatf("bp%0d_res_class", k), 64'(bus.res_class), 64'd3);
            chk($sformatf("bp%0d_in_ready", k), 64'(bus.in_ready), 64'd0);
        end

        // Result handshake; frame B still offered.
        bus.res_ready = 1'b1;
        tick();
        chk("rhs_res_valid", 64'(bus.res_valid), 64'd0);
        chk("rhs_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rhs_busy", 64'(bus.busy), 64'd0);
        chk_vec("rhs_vec", frame_a);
`ifdef NN_CTRL_PERF_EN
        chk("rhs_infer_count", 64'(bus.infer_count), 64'd1);
`endif

        // E0': frame B accepted, res_ready held high from here on.
        tick();
        chk_vec("b_vec", frame_b);
        chk("b_in_ready", 64'(bus.in_ready), 64'd0);
        bus.in_vector = frame_c;
        for (int k = 1; k <= NN_LATENCY + 2; k++) begin
            tick();
            if (k < NN_LATENCY) begin
                chk($sformatf("b%0d_res_valid", k), 64'(bus.res_valid), 64'd0);
                chk($sformatf("b%0d_vec0", k), 64'(bus.nn_input_vector[0]), 64'hBEEF);
            end else if (k == NN_LATENCY) begin
                chk("b_cap_res_valid", 64'(bus.res_valid), 64'd1);
                chk("b_cap_res_class", 64'(bus.res_class), 64'd1);
            end else if (k == NN_LATENCY + 1) begin
                chk("b_rhs_res_valid", 64'(bus.res_valid), 64'd0);
                chk("b_rhs_in_ready", 64'(bus.in_ready), 64'd1);
                chk("b_rhs_vec0", 64'(bus.nn_input_vector[0]), 64'hBEEF);
            end else begin
                // E0'+7: next frame accepted exactly here.
                chk("c_acc_vec0", 64'(bus.nn_input_vector[0]), 64'h5A5A);
                chk("c_acc_in_ready", 64'(bus.in_ready), 64'd0);
                chk("c_acc_busy", 64'(bus.busy), 64'd1);
            end
        end

        // Reset mid-WAIT: rst sampled at E0''+2.
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mrst_busy", 64'(bus.busy), 64'd0);
        chk("mrst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("mrst_res_valid", 64'(bus.res_valid), 64'd0);
        chk("mrst_res_class", 64'(bus.res_class), 64'd0);
        chk_vec("mrst_vec", zero_frame);
`ifdef NN_CTRL_PERF_EN
        chk("mrst_infer_count", 64'(bus.infer_count), 64'd0);
`endif
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 10; k++) begin
                tick();
                if (bus.res_valid) seen++;
            end
            chk("mrst_no_res_valid", 64'(seen), 64'd0);
            chk("mrst_idle_after", 64'(bus.busy), 64'd0);
        end

`ifdef NN_CTRL_PERF_EN
        // Three back-to-back frames at one per NN_LATENCY+2 cycles.
        bus.in_valid  = 1'b1;
        bus.in_vector = frame_a;
        for (int k = 0; k < 3 * (NN_LATENCY + 2); k++) begin
            tick();
        end
        chk("perf_three", 64'(bus.infer_count), 64'd3);
        bus.in_valid = 1'b0;
        tick();
        chk("perf_idle", 64'(bus.busy), 64'd0);

        force dut.infer_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.infer_count_q;
        #1;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 2 * (NN_LATENCY + 2); k++) begin
            tick();
        end
        chk("perf_saturate", 64'(bus.infer_count), 64'hFFFF);
        bus.in_valid = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
